// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared constants, state type and identity-kernel builder for
//                the 5x5 convolution filter blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int COEFF_W    = 18;  // coefficient width, matches DSP B port
    localparam int NTAPS      = 25;  // 5x5 kernel
    localparam int CENTER_TAP = 12;  // row-major centre of the 5x5 kernel
    localparam int COEFF_FRAC = 8;   // fractional bits of each coefficient
    localparam int KERNEL_W   = NTAPS * COEFF_W;

    // Unity gain in the coefficient's fixed-point format
    localparam logic [COEFF_W-1:0] IDENTITY_CENTER = COEFF_W'(1) << COEFF_FRAC;

    // Coefficient bank control states
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Pass-through kernel: centre tap at unity, all other taps zero
    function automatic logic [KERNEL_W-1:0] identity_kernel();
        logic [KERNEL_W-1:0] v;
        v = '0;
        v[CENTER_TAP*COEFF_W +: COEFF_W] = IDENTITY_CENTER;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_vs_edge.sv
`default_nettype none
// ============================================================================
//  Module      : conv_vs_edge
//  Description : Vertical sync register and rising-edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_vs_edge (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic vs_rise
);

    logic r_vs_q;

    // Previous-cycle copy of vsync for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_q <= 1'b0;
        end else begin
            r_vs_q <= vs;
        end
    end

    assign vs_rise = vs & ~r_vs_q;

endmodule
`default_nettype wire

// File: rtl/conv_coeff_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_coeff_ctrl
//  Description : Shadow/active coefficient banks for the 5x5 convolution
//                filter. A commit copies the shadow bank into the active bank
//                on the next vsync rising edge so no frame sees a mixed kernel.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_coeff_ctrl
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vs,
    input  logic                    wr_en,
    input  logic [4:0]              wr_addr,
    input  logic [COEFF_W-1:0]      wr_data,
    output logic                    wr_err,
    input  logic [4:0]              rd_addr,
    output logic [COEFF_W-1:0]      rd_data,
    input  logic                    commit_req,
    output logic                    pending,
    output logic                    commit_ack,
    output logic [KERNEL_W-1:0]     coeff_o
);

    localparam logic [4:0]          c_ntaps    = 5'(NTAPS);
    localparam logic [KERNEL_W-1:0] c_identity = identity_kernel();

    logic                 w_vs_rise;
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_apply;
    logic                 w_wr_ok;
    logic                 w_wr_bad;
    logic [COEFF_W-1:0]   r_shadow [NTAPS];
    logic [KERNEL_W-1:0]  w_shadow_flat;
    logic [KERNEL_W-1:0]  r_active;
    logic [COEFF_W-1:0]   r_rd_data;
    logic                 r_wr_err;
    logic                 r_commit_ack;

    conv_vs_edge u_vs_edge (
        .clk     (clk),
        .rst     (rst),
        .vs      (vs),
        .vs_rise (w_vs_rise)
    );

    // Flatten the shadow array so the active bank can load it in one cycle
    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_pack
            assign w_shadow_flat[k*COEFF_W +: COEFF_W] = r_shadow[k];
        end
    endgenerate

    // Commit state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, write qualification and bank-apply decode
    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        w_wr_ok     = 1'b0;
        w_wr_bad    = 1'b0;
        case (r_state)
            IDLE: begin
                // An edge coinciding with the request is too late to use
                if (commit_req) begin
                    w_state_nxt = PENDING;
                end
                if (wr_en) begin
                    if (wr_addr < c_ntaps) begin
                        w_wr_ok = 1'b1;
                    end else begin
                        w_wr_bad = 1'b1;
                    end
                end
            end
            PENDING: begin
                // Shadow is frozen while a commit waits, including the apply cycle
                w_wr_bad = wr_en;
                if (w_vs_rise) begin
                    w_state_nxt = IDLE;
                    w_apply     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shadow bank writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_shadow[k] <= c_identity[k*COEFF_W +: COEFF_W];
            end
        end else if (w_wr_ok) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end

    // Active bank loads the whole shadow bank on the vsync edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= c_identity;
        end else if (w_apply) begin
            r_active <= w_shadow_flat;
        end
    end

    // Registered readback, status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data    <= '0;
            r_wr_err     <= 1'b0;
            r_commit_ack <= 1'b0;
        end else begin
            r_rd_data    <= (rd_addr < c_ntaps) ? r_shadow[rd_addr] : '0;
            r_wr_err     <= w_wr_bad;
            r_commit_ack <= w_apply;
        end
    end

    assign rd_data    = r_rd_data;
    assign wr_err     = r_wr_err;
    assign commit_ack = r_commit_ack;
    assign pending    = (r_state == PENDING);
    assign coeff_o    = r_active;

endmodule
`default_nettype wire

// File: tb/tb_conv_coeff_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_coeff_ctrl
//  Description : Self-checking bench for conv_coeff_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_coeff_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         vs;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [17:0]  wr_data;
    logic         wr_err;
    logic [4:0]   rd_addr;
    logic [17:0]  rd_data;
    logic         commit_req;
    logic         pending;
    logic         commit_ack;
    logic [449:0] coeff_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr_en;
        logic [4:0]  addr;
        logic [17:0] data;
        logic        exp_err;
        logic [17:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    conv_coeff_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vs         (vs),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .commit_req (commit_req),
        .pending    (pending),
        .commit_ack (commit_ack),
        .coeff_o    (coeff_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [449:0] act, input logic [449:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic write_tap(input logic [4:0] a, input logic [17:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    logic [449:0] ident;
    logic [449:0] box;
    logic [449:0] exp_act;
    int           bad;
    int           acks;

    initial begin
        ident = '0;
        ident[12*18 +: 18] = 18'd256;
        for (int k = 0; k < 25; k++) box[k*18 +: 18] = 18'd16;

        tbl[0] = '{1'b1, 5'd0,  18'd5,       1'b0, 18'd5};
        tbl[1] = '{1'b1, 5'd24, 18'h3FFF9,   1'b0, 18'h3FFF9};
        tbl[2] = '{1'b1, 5'd25, 18'd99,      1'b1, 18'd0};
        tbl[3] = '{1'b1, 5'd31, 18'd1,       1'b1, 18'd0};
        tbl[4] = '{1'b1, 5'd12, 18'h1FFFF,   1'b0, 18'h1FFFF};
        tbl[5] = '{1'b1, 5'd1,  18'h20000,   1'b0, 18'h20000};
        tbl[6] = '{1'b0, 5'd12, 18'd55,      1'b0, 18'h1FFFF};
        tbl[7] = '{1'b0, 5'd6,  18'd9,       1'b0, 18'd0};

        rst = 1'b1; vs = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; commit_req = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_coeff", coeff_o, ident);
        check("reset_pending", pending, 1'b0);
        check("reset_ack", commit_ack, 1'b0);
        check("reset_wr_err", wr_err, 1'b0);
        check("reset_rd_data", rd_data, 18'd0);
        rst = 1'b0;
        tick();

        // Table-driven writes and readback in IDLE
        for (int i = 0; i < 8; i++) begin
            wr_en   = tbl[i].wr_en;
            wr_addr = tbl[i].addr;
            wr_data = tbl[i].data;
            tick();
            check("tbl_wr_err", wr_err, tbl[i].exp_err);
            wr_en   = 1'b0;
            rd_addr = tbl[i].addr;
            tick();
            check("tbl_rd_data", rd_data, tbl[i].exp_rd);
        end
        check("tbl_active_untouched", coeff_o, ident);

        // Box blur, commit, vsync 40 cycles later
        for (int k = 0; k < 25; k++) write_tap(5'(k), 18'd16);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("box_pending_set", pending, 1'b1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (coeff_o !== ident || commit_ack !== 1'b0 || pending !== 1'b1) bad++;
        end
        check("box_hold_before_vs", bad, 0);
        vs = 1'b1;
        tick();
        check("box_coeff_applied", coeff_o, box);
        check("box_ack", commit_ack, 1'b1);
        check("box_pending_clr", pending, 1'b0);
        tick();
        check("box_ack_single", commit_ack, 1'b0);
        check("box_coeff_kept", coeff_o, box);
        vs = 1'b0;
        tick();

        // Rejected writes while PENDING, including the apply cycle
        exp_act = box;
        exp_act[3*18 +: 18] = 18'd100;
        write_tap(5'd3, 18'd100);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 18'd77;
        tick();
        check("pend_wr_err", wr_err, 1'b1);
        wr_en = 1'b0; rd_addr = 5'd3;
        tick();
        check("pend_rd_tap3", rd_data, 18'd100);
        check("pend_still", pending, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 18'd55; vs = 1'b1;
        tick();
        check("edge_wr_err", wr_err, 1'b1);
        check("edge_ack", commit_ack, 1'b1);
        wr_en = 1'b0; rd_addr = 5'd4;
        tick();
        check("edge_rd_tap4", rd_data, 18'd16);
        check("edge_coeff", coeff_o, exp_act);
        vs = 1'b0;
        tick();

        // Commit request in the same cycle as the vsync edge
        write_tap(5'd0, 18'd1);
        commit_req = 1'b1; vs = 1'b1;
        tick();
        commit_req = 1'b0;
        check("simul_pending", pending, 1'b1);
        check("simul_no_ack", commit_ack, 1'b0);
        bad = 0;
        repeat (3) begin
            tick();
            if (commit_ack !== 1'b0 || coeff_o !== exp_act) bad++;
        end
        check("simul_no_apply", bad, 0);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        exp_act[0 +: 18] = 18'd1;
        check("simul_ack_next", commit_ack, 1'b1);
        check("simul_coeff_next", coeff_o, exp_act);
        check("simul_pending_clr", pending, 1'b0);
        vs = 1'b0;
        tick();

        // Repeated commit while PENDING
        write_tap(5'd0, 18'd2);
        repeat (3) begin
            commit_req = 1'b1;
            tick();
            commit_req = 1'b0;
            tick();
        end
        check("rep_pending", pending, 1'b1);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) vs = 1'b1;
            tick();
            acks += int'(commit_ack);
        end
        vs = 1'b0;
        exp_act[0 +: 18] = 18'd2;
        check("rep_single_ack", acks, 1);
        check("rep_coeff", coeff_o, exp_act);
        check("rep_pending_clr", pending, 1'b0);
        tick();

        // Reset while PENDING drops the commit
        write_tap(5'd12, 18'd3);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("rst_pend_set", pending, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pend_clr", pending, 1'b0);
        check("rst_coeff_ident", coeff_o, ident);
        rd_addr = 5'd12;
        acks = 0;
        vs = 1'b1;
        repeat (5) begin
            tick();
            acks += int'(commit_ack);
        end
        vs = 1'b0;
        check("rst_no_ack", acks, 0);
        check("rst_coeff_after_vs", coeff_o, ident);
        check("rst_rd_center", rd_data, 18'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
